// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding fetch, IF/ID pipeline register,
// one-entry skid buffer for responses that arrive while decode is stalled,
// and redirect handling that flushes IF/ID and discards in-flight responses.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic [6:0]  ifid_opcode_o
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        req_reg;
    logic        ifid_valid_reg, ifid_valid_next;
    logic [31:0] ifid_pc_reg, ifid_pc_next;
    logic [31:0] ifid_instr_reg, ifid_instr_next;
    logic        skid_valid_reg, skid_valid_next;
    logic [31:0] skid_instr_reg, skid_instr_next;

    logic [31:0] pc_inc;
    logic        ifid_free;

    assign pc_inc    = pc_reg + 32'd4;
    assign ifid_free = !ifid_valid_reg || !stall_i;

    // Next-state, PC, IF/ID and skid-buffer update; redirect overrides everything last.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ifid_valid_next = ifid_valid_reg;
        ifid_pc_next    = ifid_pc_reg;
        ifid_instr_next = ifid_instr_reg;
        skid_valid_next = skid_valid_reg;
        skid_instr_next = skid_instr_reg;

        // Decode takes the held instruction; a bubble replaces it unless refilled below.
        if (ifid_valid_reg && !stall_i) begin
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
        end

        case (state_reg)
            IDLE: state_next = REQ;
            REQ:  state_next = WAIT;
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (ifid_free) begin
                        ifid_valid_next = 1'b1;
                        ifid_pc_next    = pc_reg;
                        ifid_instr_next = imem_rdata_i;
                        pc_next         = pc_inc;
                        state_next      = REQ;
                    end else begin
                        skid_valid_next = 1'b1;
                        skid_instr_next = imem_rdata_i;
                        state_next      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_i && skid_valid_reg) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = pc_reg;
                    ifid_instr_next = skid_instr_reg;
                    skid_valid_next = 1'b0;
                    pc_next         = pc_inc;
                    state_next      = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase

        if (redirect_i) begin
            pc_next         = {redirect_pc_i[31:2], 2'b00};
            ifid_valid_next = 1'b0;
            ifid_instr_next = NOP_INSTR;
            skid_valid_next = 1'b0;
            case (state_reg)
                REQ:     state_next = DROP;
                WAIT:    state_next = imem_rvalid_i ? REQ : DROP;
                DROP:    state_next = imem_rvalid_i ? REQ : DROP;
                default: state_next = REQ;
            endcase
        end
    end

    // State registers; the fetch request is registered so it is high exactly in REQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            pc_reg         <= RESET_PC;
            req_reg        <= 1'b0;
            ifid_valid_reg <= 1'b0;
            ifid_pc_reg    <= 32'h0000_0000;
            ifid_instr_reg <= NOP_INSTR;
            skid_valid_reg <= 1'b0;
            skid_instr_reg <= NOP_INSTR;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            req_reg        <= (state_next == REQ);
            ifid_valid_reg <= ifid_valid_next;
            ifid_pc_reg    <= ifid_pc_next;
            ifid_instr_reg <= ifid_instr_next;
            skid_valid_reg <= skid_valid_next;
            skid_instr_reg <= skid_instr_next;
        end
    end

    assign imem_req_o    = req_reg;
    assign imem_addr_o   = pc_reg;
    assign ifid_valid_o  = ifid_valid_reg;
    assign ifid_pc_o     = ifid_pc_reg;
    assign ifid_instr_o  = ifid_instr_reg;
    assign ifid_opcode_o = ifid_instr_reg[6:0];

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  1  decode not ready; IF/ID register holds.
REQ-006 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-007 redirect_pc_i  input  32  redirect target address.
REQ-008 imem_req_o  output  1  registered fetch request, one-cycle pulse.
REQ-009 imem_addr_o  output  32  fetch address, valid while imem_req_o=1.
REQ-010 imem_rvalid_i  input  1  instruction memory response valid.
REQ-011 imem_rdata_i  input  32  instruction word, valid with imem_rvalid_i.
REQ-012 ifid_valid_o  output  1  IF/ID register holds a live instruction.
REQ-013 ifid_pc_o  output  32  PC of held instruction.
REQ-014 ifid_instr_o  output  32  held instruction word.
REQ-015 ifid_opcode_o  output  7  ifid_instr_o[6:0]; drives the control-logic decoder.

Function
REQ-016 FSM states IDLE, REQ, WAIT, HOLD, DROP; one fetch outstanding at most.
REQ-017 IDLE -> REQ unconditionally on the first clock after reset release.
REQ-018 REQ: imem_req_o=1, imem_addr_o=pc; memory accepts unconditionally; next state WAIT (DROP if redirect_i same cycle).
REQ-019 WAIT, imem_rvalid_i=1, IF/ID free (ifid_valid_o=0 or stall_i=0): load IF/ID with {1, pc, imem_rdata_i}, pc<=pc+4, -> REQ.
REQ-020 WAIT, imem_rvalid_i=1, IF/ID occupied and stall_i=1: capture word into one-entry skid buffer, -> HOLD.
REQ-021 HOLD, stall_i=0: skid buffer moves to IF/ID, pc<=pc+4, -> REQ; stall_i=1: remain.
REQ-022 Fetch-to-IF/ID latency with 1-cycle memory and no stall: 2 cycles; sustained throughput one instruction per 2 cycles.
REQ-023 IF/ID consumed when ifid_valid_o=1 and stall_i=0; if no new word loads that cycle, ifid_valid_o<=0 and ifid_instr_o<=NOP_INSTR.
REQ-024 stall_i=1 with ifid_valid_o=1: ifid_pc_o, ifid_instr_o, ifid_valid_o hold unchanged.
REQ-025 redirect_i has priority over stall_i and every response: pc<={redirect_pc_i[31:2],2'b00}, ifid_valid_o<=0, ifid_instr_o<=NOP_INSTR, skid buffer cleared.
REQ-026 Redirect in REQ, or in WAIT without imem_rvalid_i: -> DROP; in WAIT with imem_rvalid_i, HOLD, or IDLE: -> REQ, response discarded.
REQ-027 DROP: discard next imem_rvalid_i word, then -> REQ; further redirect in DROP updates pc only.
REQ-028 PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
REQ-029 imem_rvalid_i in IDLE, REQ or HOLD is ignored.

Reset
REQ-030 rst_n=0 asynchronously forces: state IDLE, pc=RESET_PC, imem_req_o=0, imem_addr_o=RESET_PC, ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_opcode_o=7'b0010011, skid empty.
REQ-031 Reset mid-fetch abandons the outstanding request; first request after release is at RESET_PC on the second clock edge.

Verification
REQ-032 Reset release, 1-cycle memory returning 32'h0000_0033 at 0x0 -> imem_req_o at 0x0, then ifid_valid_o=1, ifid_pc_o=0x0, ifid_opcode_o=7'b0110011.
REQ-033 Sequential stream 0x0,0x4,0x8 words R-type/load/store -> ifid_opcode_o 0110011, 0000011, 0100011 in order, ifid_pc_o matching.
REQ-034 stall_i=1 for 5 cycles with response arriving -> IF/ID unchanged, state HOLD, no imem_req_o; after release next instruction appears, none lost or duplicated.
REQ-035 redirect_i=1, redirect_pc_i=0x100 while in WAIT -> ifid_valid_o=0 next cycle, late response discarded, next imem_addr_o=0x100.
REQ-036 redirect_pc_i=0x102 -> fetch address 0x100; pc at 0xFFFF_FFFC advances to 0x0000_0000.
REQ-037 rst_n asserted while in WAIT -> all outputs at REQ-030 values immediately, without a clock edge.
